// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access stage: bus widths,
// load/store size encodings and the read-latency FSM states.
package mem_access_pkg;

  localparam int EXE_MEM_W = 157;
  localparam int MEM_WB_W  = 154;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational alignment for the memory stage: store byte lanes and data,
// load extraction with sign/zero extension, and address-error detection.
module mem_align
  import mem_access_pkg::*;
(
  input  logic        load_i,
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_val_o,
  output logic        adel_o,
  output logic        ades_o
);

  logic misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign misalign = ((size_i == SIZE_HALF) && addr_lo_i[0]) ||
                    ((size_i == SIZE_WORD) && (addr_lo_i != 2'b00));
  assign adel_o = load_i & misalign;
  assign ades_o = store_i & misalign;

  always_comb begin
    wen_mask_o = 4'b0000;
    wdata_o    = store_data_i;
    unique case (size_i)
      SIZE_BYTE: begin
        wen_mask_o = 4'b0001 << addr_lo_i;
        wdata_o    = {4{store_data_i[7:0]}};
      end
      SIZE_HALF: begin
        wen_mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{store_data_i[15:0]}};
      end
      default: begin
        wen_mask_o = 4'hF;
        wdata_o    = store_data_i;
      end
    endcase
  end

  always_comb begin
    byte_sel = rdata_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (size_i)
      SIZE_BYTE: load_val_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_val_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:   load_val_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives the data RAM, covers its one-cycle
// read latency and holds the result while write-back stalls.
//
//   state | meaning
//   IDLE  | accepting; non-loads and faulting loads finish combinationally
//   WAIT  | aligned load issued, read data arriving on dm_rdata this cycle
//   HOLD  | result held (load data in load_data_q) until write-back accepts
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 WB_allow_in,
  input  logic                 cancel,
  input  logic [31:0]          dm_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc
);

  logic        ld, st, is_unsigned;
  logic [1:0]  size;
  logic [31:0] store_data, exe_result, lo_result, pc;
  logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall, eret, brk, ov, wen_in;
  logic [4:0]  wdest;

  assign {ld, st, size, is_unsigned, store_data, exe_result, lo_result,
          hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr,
          syscall, eret, brk, ov, wen_in, wdest, pc} = EXE_MEM_bus_r;

  state_e      state_q, state_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] rdata_sel, load_val, wdata, mem_result;
  logic [3:0]  wen_mask;
  logic        adel, ades, exc_in, read_issue, store_issue, store_en;

  mem_align u_align (
    .load_i       (ld),
    .store_i      (st),
    .size_i       (size),
    .unsigned_i   (is_unsigned),
    .addr_lo_i    (exe_result[1:0]),
    .store_data_i (store_data),
    .rdata_i      (rdata_sel),
    .wen_mask_o   (wen_mask),
    .wdata_o      (wdata),
    .load_val_o   (load_val),
    .adel_o       (adel),
    .ades_o       (ades)
  );

  assign exc_in      = syscall | brk | ov;
  assign read_issue  = ld & ~adel & ~exc_in & ~cancel;
  assign store_issue = st & ~ades & ~exc_in & ~cancel;

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    rdata_sel   = load_data_q;
    MEM_over    = 1'b0;
    store_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MEM_valid) begin
          if (read_issue) state_d  = WAIT;
          else            MEM_over = 1'b1;
          if (store_issue) begin
            store_en = 1'b1;
            if (!WB_allow_in) state_d = HOLD;
          end
        end
      end
      WAIT: begin
        MEM_over    = MEM_valid;
        rdata_sel   = dm_rdata;
        load_data_d = dm_rdata;
        state_d     = WB_allow_in ? IDLE : HOLD;
      end
      HOLD: begin
        MEM_over = MEM_valid;
        if (WB_allow_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush abandons whatever is in flight, including a store not yet written.
    if (cancel) begin
      state_d  = IDLE;
      store_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  assign dm_addr    = {exe_result[31:2], 2'b00};
  assign dm_wen     = (store_en && MEM_valid) ? wen_mask : 4'b0000;
  assign dm_wdata   = wdata;
  assign mem_result = (ld & ~adel) ? load_val : exe_result;
  assign MEM_wdest  = wdest & {5{MEM_valid}};
  assign MEM_pc     = pc;

  assign MEM_WB_bus = {wen_in & ~adel & ~ades, wdest, mem_result, lo_result,
                       hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr,
                       syscall, eret, pc, exe_result, brk, ov, adel, ades};

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed instructions push expected
// write-back results; a monitor pops and compares on each accepted result.
module tb_mem_access;

  logic         clk = 1'b0;
  logic         resetn;
  logic         MEM_valid;
  logic [156:0] EXE_MEM_bus_r;
  logic         WB_allow_in;
  logic         cancel;
  logic [31:0]  dm_rdata;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic         MEM_over;
  logic [153:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_pc;

  mem_access dut (
    .clk           (clk),
    .resetn        (resetn),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .WB_allow_in   (WB_allow_in),
    .cancel        (cancel),
    .dm_rdata      (dm_rdata),
    .dm_addr       (dm_addr),
    .dm_wen        (dm_wen),
    .dm_wdata      (dm_wdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_pc        (MEM_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        wen;
    logic        adel;
    logic        ades;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  logic [3:0]  last_wen;
  logic [31:0] last_wdata;
  logic [31:0] ram [0:63];

  // Behavioural synchronous RAM: byte-enabled write, one-cycle read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_wen[b]) ram[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    dm_rdata <= ram[dm_addr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dm_wen != 4'b0000) begin
      pulses++;
      last_wen   = dm_wen;
      last_wdata = dm_wdata;
    end
    if (resetn && MEM_valid && MEM_over && WB_allow_in) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mem_result", MEM_WB_bus[147:116], e.res);
        check("wb_wen", {31'd0, MEM_WB_bus[153]}, {31'd0, e.wen});
        check("adel", {31'd0, MEM_WB_bus[1]}, {31'd0, e.adel});
        check("ades", {31'd0, MEM_WB_bus[0]}, {31'd0, e.ades});
        check("dm_addr_field", MEM_WB_bus[35:4], e.addr);
        check("mem_pc", MEM_pc, 32'hBFC0_0000 ^ e.addr);
      end
    end
  end

  function automatic logic [156:0] mk(input logic ld, input logic st, input logic [1:0] sz,
                                      input logic uns, input logic [31:0] sdata,
                                      input logic [31:0] res, input logic wen, input logic ov);
    return {ld, st, sz, uns, sdata, res, 32'h0, 6'b0, 8'h0,
            1'b0, 1'b0, 1'b0, ov, wen, 5'd3, 32'hBFC0_0000 ^ res};
  endfunction

  function automatic exp_t ex(input logic [31:0] res, input logic wen, input logic adel,
                              input logic ades, input logic [31:0] addr);
    exp_t e;
    e.res = res; e.wen = wen; e.adel = adel; e.ades = ades; e.addr = addr;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic run_instr(input string name, input logic [156:0] bus, input int stall,
                           input bit exp_wait, input exp_t e, input int exp_pulses,
                           input bit corrupt, input int cidx, input logic [31:0] cval);
    int  cyc;
    int  p0;
    bit  done;
    p0   = pulses;
    exp_q.push_back(e);
    MEM_valid     = 1'b1;
    EXE_MEM_bus_r = bus;
    WB_allow_in   = (stall == 0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (cyc == 0) check({name, "_over_arrival"}, {31'd0, MEM_over}, {31'd0, !exp_wait});
      done = MEM_over && WB_allow_in;
      @(posedge clk); #1;
      cyc++;
      if (corrupt && cyc == 1) ram[cidx] = cval;
      if (cyc >= stall) WB_allow_in = 1'b1;
    end
    if (!done) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      exp_q.delete();
    end
    check({name, "_wen_pulses"}, pulses - p0, exp_pulses);
    MEM_valid   = 1'b0;
    WB_allow_in = 1'b1;
  endtask

  initial begin
    resetn        = 1'b0;
    MEM_valid     = 1'b0;
    EXE_MEM_bus_r = '0;
    WB_allow_in   = 1'b1;
    cancel        = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4]  = 32'h80FF_0000;
    ram[24] = 32'h8001_1234;
    ram[32] = 32'hCAFE_F00D;
    ram[36] = 32'h1234_5678;

    @(negedge clk);
    check("rst_dm_wen", {28'd0, dm_wen}, 32'd0);
    check("rst_mem_over", {31'd0, MEM_over}, 32'd0);
    check("rst_wdest", {27'd0, MEM_wdest}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_instr("lb", mk(1,0,2'b00,0,0,32'h13,1,0), 0, 1, ex(32'hFFFF_FF80,1,0,0,32'h13), 0, 0, 0, 0);
    run_instr("lbu", mk(1,0,2'b00,1,0,32'h13,1,0), 0, 1, ex(32'h0000_0080,1,0,0,32'h13), 0, 0, 0, 0);
    run_instr("lh_mis", mk(1,0,2'b01,0,0,32'h21,1,0), 0, 0, ex(32'h21,0,1,0,32'h21), 0, 0, 0, 0);
    run_instr("lh", mk(1,0,2'b01,0,0,32'h62,1,0), 0, 1, ex(32'hFFFF_8001,1,0,0,32'h62), 0, 0, 0, 0);
    run_instr("lb1", mk(1,0,2'b00,0,0,32'h61,1,0), 0, 1, ex(32'h0000_0012,1,0,0,32'h61), 0, 0, 0, 0);
    run_instr("lhu", mk(1,0,2'b01,1,0,32'h60,1,0), 0, 1, ex(32'h0000_1234,1,0,0,32'h60), 0, 0, 0, 0);

    run_instr("sw", mk(0,1,2'b10,0,32'h1122_3344,32'h10,0,0), 0, 0, ex(32'h10,0,0,0,32'h10), 1, 0, 0, 0);
    check("sw_wen", {28'd0, last_wen}, 32'h0000_000F);
    check("sw_wdata", last_wdata, 32'h1122_3344);
    check("sw_ram", ram[4], 32'h1122_3344);

    run_instr("sh", mk(0,1,2'b01,0,32'h0000_ABCD,32'h42,0,0), 0, 0, ex(32'h42,0,0,0,32'h42), 1, 0, 0, 0);
    check("sh_wen", {28'd0, last_wen}, 32'h0000_000C);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);

    run_instr("sb", mk(0,1,2'b00,0,32'h0000_005A,32'h45,0,0), 0, 0, ex(32'h45,0,0,0,32'h45), 1, 0, 0, 0);
    check("sb_wen", {28'd0, last_wen}, 32'h0000_0002);
    check("sb_wdata", last_wdata, 32'h5A5A_5A5A);

    run_instr("lw_hold", mk(1,0,2'b10,0,0,32'h80,1,0), 3, 1, ex(32'hCAFE_F00D,1,0,0,32'h80), 0, 1, 32, 32'h0);

    run_instr("sw_stall", mk(0,1,2'b10,0,32'hDEAD_BEEF,32'h50,0,0), 2, 0, ex(32'h50,0,0,0,32'h50), 1, 0, 0, 0);
    check("sw_stall_ram", ram[20], 32'hDEAD_BEEF);
    run_instr("sw_mis", mk(0,1,2'b10,0,32'h5555_5555,32'h51,0,0), 0, 0, ex(32'h51,0,0,1,32'h51), 0, 0, 0, 0);
    run_instr("sw_ov", mk(0,1,2'b10,0,32'h7777_7777,32'h54,0,1), 0, 0, ex(32'h54,0,0,0,32'h54), 0, 0, 0, 0);
    run_instr("alu", mk(0,0,2'b00,0,0,32'h1234_5670,1,0), 0, 0, ex(32'h1234_5670,1,0,0,32'h1234_5670), 0, 0, 0, 0);

    // cancel while the read is outstanding
    MEM_valid = 1'b1; EXE_MEM_bus_r = mk(1,0,2'b10,0,0,32'h90,1,0); WB_allow_in = 1'b0;
    @(negedge clk);
    check("cancel_arrival_over", {31'd0, MEM_over}, 32'd0);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_wait_over", {31'd0, MEM_over}, 32'd1);
    @(posedge clk); #1;
    cancel = 1'b0; MEM_valid = 1'b0; WB_allow_in = 1'b1;
    @(negedge clk);
    check("cancel_over_after", {31'd0, MEM_over}, 32'd0);
    @(posedge clk); #1;
    run_instr("lw_after_cancel", mk(1,0,2'b10,0,0,32'h90,1,0), 0, 1, ex(32'h1234_5678,1,0,0,32'h90), 0, 0, 0, 0);

    // a flushed store must never reach the RAM
    begin
      int p0;
      p0 = pulses;
      MEM_valid = 1'b1; EXE_MEM_bus_r = mk(0,1,2'b10,0,32'hFFFF_FFFF,32'h90,0,0);
      WB_allow_in = 1'b0; cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0; MEM_valid = 1'b0; WB_allow_in = 1'b1;
      @(posedge clk); #1;
      check("cancel_store_pulses", pulses - p0, 0);
      check("cancel_store_ram", ram[36], 32'h1234_5678);
    end

    // reset asserted while in WAIT
    MEM_valid = 1'b1; EXE_MEM_bus_r = mk(1,0,2'b10,0,0,32'h80,1,0); WB_allow_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_over_before", {31'd0, MEM_over}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rst_wait_over_during", {31'd0, MEM_over}, 32'd0);
    check("rst_wait_dm_wen", {28'd0, dm_wen}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; MEM_valid = 1'b0; WB_allow_in = 1'b1;
    @(posedge clk); #1;
    run_instr("lw_after_rst", mk(1,0,2'b10,0,0,32'h80,1,0), 0, 1, ex(32'h0,1,0,0,32'h80), 0, 0, 0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
